// File: rtl/sseg_pkg.sv
// Shared seven-segment constants and the hex-to-glyph lookup.
// All segment values are active-low for a common-anode display.
package sseg_pkg;

   localparam logic [7:0] SEG_OFF   = 8'hFF;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Index is the nibble value; bit order is g..a.
   localparam logic [6:0] SEG_GLYPH [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
      return SEG_GLYPH[nib];
   endfunction

endpackage

// File: rtl/sseg_digit_decode.sv
// Combinational decode of one digit to an active-low segment byte.
// Zero latency; blank darkens the glyph but leaves the decimal point alone.
module sseg_digit_decode
   import sseg_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       dp,
   input  logic       blank,
   output logic [7:0] seg
);

   assign seg = {~dp, blank ? SEG_BLANK : seg_glyph(nibble)};

endmodule

// File: rtl/sseg_scan_driver.sv
// N-digit multiplexed seven-segment scanner with double-buffered digit data.
// Outputs are registered one cycle behind the scan counters; each slot opens with a dark guard cycle.
module sseg_scan_driver
   import sseg_pkg::*;
#(
   parameter int N_DIGITS = 8,
   parameter int DIV      = 100000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [4*N_DIGITS-1:0]   hex_in,
   input  logic [N_DIGITS-1:0]     dp_in,
   input  logic [N_DIGITS-1:0]     en_in,
   input  logic                    lz_blank,
   output logic [N_DIGITS-1:0]     an,
   output logic [7:0]              sseg,
   output logic                    frame_done
);

   localparam int TICK_W = $clog2(DIV);
   localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);

   logic [TICK_W-1:0]           tick_q, tick_d;
   logic [IDX_W-1:0]            idx_q, idx_d;

   logic [N_DIGITS-1:0][3:0]    sh_hex_q;
   logic [N_DIGITS-1:0]         sh_dp_q;
   logic [N_DIGITS-1:0]         sh_en_q;
   logic                        sh_lz_q;
   logic                        pending_q, pending_d;

   logic [N_DIGITS-1:0][3:0]    ac_hex_q;
   logic [N_DIGITS-1:0]         ac_dp_q;
   logic [N_DIGITS-1:0]         ac_en_q;
   logic [N_DIGITS-1:0]         mask_q, mask_d;

   logic [N_DIGITS-1:0]         an_q, an_d;
   logic [7:0]                  sseg_q, sseg_d;
   logic                        fd_q;

   logic                        tick_last, idx_last, commit;
   logic                        leading;
   logic [7:0]                  dec_seg;

   assign tick_last = (tick_q == TICK_LAST);
   assign idx_last  = (idx_q == IDX_LAST);
   assign commit    = tick_last && idx_last;

   always_comb begin
      tick_d = tick_last ? '0 : tick_q + 1'b1;
      idx_d  = idx_q;
      if (tick_last) begin
         idx_d = idx_last ? '0 : idx_q + 1'b1;
      end
   end

   // A load on the commit edge re-arms pending so its data lands one frame later.
   always_comb begin
      pending_d = pending_q;
      if (load) begin
         pending_d = 1'b1;
      end else if (commit) begin
         pending_d = 1'b0;
      end
   end

   // Leading-zero mask from the buffer about to go live; disabled digits are skipped
   // without ending the run, and digit 0 always shows.
   always_comb begin
      mask_d  = '0;
      leading = sh_lz_q;
      for (int k = N_DIGITS - 1; k >= 1; k--) begin
         if (sh_en_q[k]) begin
            if (leading && (sh_hex_q[k] == 4'h0)) begin
               mask_d[k] = 1'b1;
            end else begin
               leading = 1'b0;
            end
         end
      end
   end

   sseg_digit_decode u_decode (
      .nibble (ac_hex_q[idx_q]),
      .dp     (ac_dp_q[idx_q]),
      .blank  (mask_q[idx_q]),
      .seg    (dec_seg)
   );

   always_comb begin
      an_d   = '1;
      sseg_d = SEG_OFF;
      if ((tick_q != '0) && ac_en_q[idx_q]) begin
         an_d[idx_q] = 1'b0;
         sseg_d      = dec_seg;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tick_q    <= '0;
         idx_q     <= '0;
         sh_hex_q  <= '0;
         sh_dp_q   <= '0;
         sh_en_q   <= '0;
         sh_lz_q   <= 1'b0;
         pending_q <= 1'b0;
         ac_hex_q  <= '0;
         ac_dp_q   <= '0;
         ac_en_q   <= '0;
         mask_q    <= '0;
         an_q      <= '1;
         sseg_q    <= SEG_OFF;
         fd_q      <= 1'b0;
      end else begin
         tick_q    <= tick_d;
         idx_q     <= idx_d;
         pending_q <= pending_d;
         if (load) begin
            sh_hex_q <= hex_in;
            sh_dp_q  <= dp_in;
            sh_en_q  <= en_in;
            sh_lz_q  <= lz_blank;
         end
         // Without pending the shadow already equals the active copy.
         if (commit && pending_q) begin
            ac_hex_q <= sh_hex_q;
            ac_dp_q  <= sh_dp_q;
            ac_en_q  <= sh_en_q;
            mask_q   <= mask_d;
         end
         an_q   <= an_d;
         sseg_q <= sseg_d;
         fd_q   <= commit;
      end
   end

   assign an         = an_q;
   assign sseg       = sseg_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver with N_DIGITS = 4, DIV = 4.
module tb_sseg_scan_driver;

   logic        clk;
   logic        reset;
   logic        load;
   logic [15:0] hex_in;
   logic [3:0]  dp_in;
   logic [3:0]  en_in;
   logic        lz_blank;
   logic [3:0]  an;
   logic [7:0]  sseg;
   logic        frame_done;

   int passed = 0;
   int total  = 0;

   logic [15:0] a_hex, b_hex;
   logic [3:0]  a_en, a_dp, b_en, b_dp;
   logic        a_lz, b_lz;

   sseg_scan_driver #(.N_DIGITS(4), .DIV(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .hex_in     (hex_in),
      .dp_in      (dp_in),
      .en_in      (en_in),
      .lz_blank   (lz_blank),
      .an         (an),
      .sseg       (sseg),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      assert (act === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
   endtask

   task automatic drive_load(input logic [15:0] h, input logic [3:0] e, input logic [3:0] d,
                             input logic z);
      hex_in   = h;
      en_in    = e;
      dp_in    = d;
      lz_blank = z;
      load     = 1'b1;
   endtask

   task automatic post_step(input int k, input int la, input int lb);
      if (k == la)      drive_load(a_hex, a_en, a_dp, a_lz);
      else if (k == lb) drive_load(b_hex, b_en, b_dp, b_lz);
      else              load = 1'b0;
   endtask

   task automatic wait_fd(input string tag);
      int n;
      bit got;
      n   = 0;
      got = 1'b0;
      while (!got && n < 40) begin
         step();
         n++;
         if (frame_done === 1'b1) got = 1'b1;
      end
      chk(tag, 32'(got), 32'd1);
   endtask

   // Called on a frame_done sample; walks one full frame and ends on the next one.
   task automatic check_frame(input string name, input logic [3:0][7:0] es, input logic [3:0] lit,
                              input int la, input int lb);
      int k;
      logic [3:0] ea;
      k = 0;
      for (int d = 0; d < 4; d++) begin
         step();
         k++;
         chk($sformatf("%s d%0d guard an", name, d), 32'(an), 32'hF);
         chk($sformatf("%s d%0d guard sseg", name, d), 32'(sseg), 32'hFF);
         post_step(k, la, lb);
         ea = 4'hF;
         if (lit[d]) ea[d] = 1'b0;
         for (int t = 1; t < 4; t++) begin
            step();
            k++;
            chk($sformatf("%s d%0d t%0d an", name, d, t), 32'(an), 32'(ea));
            chk($sformatf("%s d%0d t%0d sseg", name, d, t), 32'(sseg), 32'(es[d]));
            post_step(k, la, lb);
         end
      end
      chk($sformatf("%s frame_done", name), 32'(frame_done), 32'd1);
   endtask

   task automatic dark_window(input string name, input int n);
      int cnt, last, gap;
      cnt  = 0;
      last = -1;
      gap  = 0;
      for (int i = 1; i <= n; i++) begin
         step();
         chk($sformatf("%s c%0d an", name, i), 32'(an), 32'hF);
         chk($sformatf("%s c%0d sseg", name, i), 32'(sseg), 32'hFF);
         if (frame_done === 1'b1) begin
            if (last >= 0) gap = i - last;
            last = i;
            cnt++;
         end
      end
      chk($sformatf("%s pulses", name), 32'(cnt), 32'd2);
      chk($sformatf("%s period", name), 32'(gap), 32'd16);
   endtask

   initial begin
      reset    = 1'b1;
      load     = 1'b0;
      hex_in   = '0;
      dp_in    = '0;
      en_in    = '0;
      lz_blank = 1'b0;
      repeat (10) step();
      chk("reset an", 32'(an), 32'hF);
      chk("reset sseg", 32'(sseg), 32'hFF);
      chk("reset frame_done", 32'(frame_done), 32'd0);
      reset = 1'b0;
      dark_window("boot", 40);

      // Load just after a commit: the current frame stays dark.
      wait_fd("sync0");
      drive_load(16'h1234, 4'hF, 4'h0, 1'b0);
      check_frame("pre", 32'hFFFFFFFF, 4'h0, -1, -1);

      a_hex = 16'h0050; a_en = 4'hF; a_dp = 4'h0; a_lz = 1'b1;
      check_frame("f1234", 32'hF9A4B099, 4'hF, 6, -1);

      a_hex = 16'h0000; a_en = 4'hF; a_dp = 4'h0; a_lz = 1'b1;
      check_frame("f0050", 32'hFFFF92C0, 4'hF, 6, -1);

      a_hex = 16'h8888; a_en = 4'b1011; a_dp = 4'b0100; a_lz = 1'b0;
      check_frame("f0000", 32'hFFFFFFC0, 4'hF, 6, -1);

      // Mid-frame load then a second load exactly on the commit edge.
      a_hex = 16'h0050; a_en = 4'hF; a_dp = 4'h0; a_lz = 1'b1;
      b_hex = 16'h1234; b_en = 4'hF; b_dp = 4'h0; b_lz = 1'b0;
      check_frame("f8888", 32'h80FF8080, 4'b1011, 6, 15);
      check_frame("fold", 32'hFFFF92C0, 4'hF, -1, -1);
      check_frame("fnew", 32'hF9A4B099, 4'hF, -1, -1);

      repeat (10) step();
      chk("mid d2 an", 32'(an), 32'hB);
      chk("mid d2 sseg", 32'(sseg), 32'hA4);
      reset = 1'b1;
      step();
      chk("rst an", 32'(an), 32'hF);
      chk("rst sseg", 32'(sseg), 32'hFF);
      chk("rst frame_done", 32'(frame_done), 32'd0);
      reset = 1'b0;
      dark_window("post", 40);

      drive_load(16'h1234, 4'hF, 4'h0, 1'b0);
      step();
      load = 1'b0;
      wait_fd("sync1");
      check_frame("final", 32'hF9A4B099, 4'hF, -1, -1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/sseg_scan_driver.md
# sseg_scan_driver

Time-multiplexed N-digit seven-segment display driver with per-digit enable, per-digit decimal point, optional leading-zero suppression and tear-free double-buffered loading. It sits between the timer/counter datapath and the board's common-anode display. It generalises the single-digit hex-to-segment decode to a parametrised digit count with its own refresh scan and anti-ghosting guard slot.

## Interface
Parameters:
- N_DIGITS, 8, number of digits scanned (1..16)
- DIV, 100000, clock cycles per digit slot (>= 2)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- load  in  1  single-cycle strobe; captures hex_in/dp_in/en_in/lz_blank into the shadow buffer
- hex_in  in  4*N_DIGITS  digit k is hex_in[4k+3:4k]; digit 0 is rightmost
- dp_in  in  N_DIGITS  1 = decimal point of digit k lit
- en_in  in  N_DIGITS  1 = digit k enabled; 0 = digit k fully dark
- lz_blank  in  1  1 = suppress leading zeros
- an  out  N_DIGITS  digit selects, active-low
- sseg  out  8  segments, active-low; sseg[6:0] = g..a, sseg[7] = dp
- frame_done  out  1  one-cycle pulse at every frame commit

Clock is `clk` and reset is `reset`: one clock, synchronous active-high reset.

## Operation
- tick counter runs 0..DIV-1. idx (digit index) increments when tick = DIV-1 and wraps N_DIGITS-1 -> 0.
- Shadow/active double buffer:
  - load writes the shadow buffer and sets pending.
  - Commit happens on the cycle with tick = DIV-1 and idx = N_DIGITS-1, every frame. On commit: active <= shadow, pending <= 0, frame_done = 1.
  - load in the commit cycle: active takes the old shadow, shadow takes the new inputs, and pending stays 1, so the new values apply at the next commit.
  - load without a subsequent commit never changes the display mid-frame.
- The suppression mask is computed from the active buffer at commit. When active lz_blank = 1, the mask covers enabled digits from N_DIGITS-1 downward while the nibble = 0, up to the first nonzero digit. Digit 0 is never suppressed.
- Per-slot output for digit idx:
  - Guard cycle (tick = 0): an all ones, sseg = 8'hFF.
  - en = 0: an all ones, sseg = 8'hFF for the whole slot.
  - Suppressed: an[idx] = 0, sseg[6:0] = 7'h7F, sseg[7] = ~dp.
  - Otherwise: an[idx] = 0, sseg[6:0] = active-low hex glyph, sseg[7] = ~dp.
  - Glyphs (as sseg[6:0]): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.

## Timing
- Reset values:
  - Outputs: an = all ones, sseg = 8'hFF, frame_done = 0.
  - Internal: tick = 0, idx = 0, pending = 0, shadow and active buffers all zero (en = 0), so the display stays dark until the first load and commit.
- an and sseg are registered and lag internal tick/idx by one cycle. frame_done is registered with the same lag.
- Each digit is lit for DIV-1 cycles after its 1-cycle guard. Frame period = N_DIGITS*DIV cycles.
- Data loaded before a commit is visible from the first lit cycle of the following digit-0 slot.
- Worst-case load-to-display latency: N_DIGITS*DIV + 2 cycles.
- Reset mid-frame: outputs go to reset values on the next edge, buffers clear, and the scan restarts at digit 0.
- Widths:
  - tick is $clog2(DIV) bits.
  - idx is max(1, $clog2(N_DIGITS)) bits.
  - Wrap is by explicit compare, not overflow, so non-power-of-two N_DIGITS and DIV are legal.

## Structure
- Shared package sseg_pkg holds:
  - SEG_OFF = 8'hFF
  - the 16-entry glyph constant array
  - a function seg_glyph(logic [3:0]) returning logic [6:0]
- Sub-module sseg_digit_decode: inputs nibble, dp, blank; output 8-bit active-low segment byte. It is purely combinational and instantiated once on the muxed digit.
- The top level holds the counters, buffers, suppression mask and output registers.

## Test plan
All scenarios use N_DIGITS = 4, DIV = 4.
- Reset held 10 cycles, then 40 cycles with no load -> an = 4'hF, sseg = 8'hFF, frame_done pulses every 16 cycles.
- Load hex_in = 16'h1234, en_in = 4'hF, dp_in = 0 -> after the next frame_done, each slot has 1 guard cycle (an = F, sseg = FF) then 3 cycles:
  - an = E, sseg = 99
  - an = D, sseg = B0
  - an = B, sseg = A4
  - an = 7, sseg = F9
- Load hex_in = 16'h0050, lz_blank = 1, en_in = F -> digits 3 and 2 have an low with sseg = FF, digit 1 shows sseg = 92, digit 0 shows sseg = C0. Repeat with hex_in = 0: only digit 0 shows C0.
- Load dp_in = 4'b0100, hex_in = 16'h8888, en_in = 4'b1011 -> digit 2 is dark (an = F for the whole slot), the other digits show sseg = 80, and no dp is lit.
- Load mid-frame -> display unchanged until frame_done. Load exactly on the commit cycle -> old shadow shows for one frame, new data the frame after.
- Assert reset mid-slot of digit 2 -> next cycle an = F, sseg = FF, and the display stays dark until a new load and commit.
